// File: rtl/pixel_arb_pkg.sv
// Purpose : shared widths, state encoding and defaults for the pixel port arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package pixel_arb_pkg;

  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int COL_W       = 3;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pixel_port_arbiter_rr_pick.sv
// Purpose : combinational round-robin picker; first set req bit at or above ptr, wrapping.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when the pick is used.
// Ports   : req (level requests), ptr (search start index),
//           win_onehot / win_idx (winner), win_vld (any request present).
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_vld
);

  int w_j;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    w_j        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      // Candidate index is ptr+off modulo N_REQ; one subtraction suffices
      // because both ptr and off are below N_REQ.
      w_j = int'(ptr) + off;
      if (w_j >= N_REQ) begin
        w_j = w_j - N_REQ;
      end
      if (!win_vld && req[w_j]) begin
        win_vld         = 1'b1;
        win_onehot[w_j] = 1'b1;
        win_idx         = PTR_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Purpose : shares the VGA adapter pixel write port between N_REQ renderers, round-robin, burst-held grant.
// Latency : request->grant 1 edge; accepted beat->vga_* 1 edge; one IDLE bubble between bursts.
// Backpr. : only the granted requester's px_valid is accepted; others wait on gnt (no preemption).
// Ports   : clk, resetn (async active-low), frame_start (resets RR pointer),
//           req/px_valid/px_last/px_x/px_y/px_colour (per requester, packed),
//           gnt (one-hot, registered), vga_x/vga_y/vga_colour/vga_plot (registered pixel),
//           busy (in BURST), timeout_err (sticky watchdog flag).
// Config  : define ARB_WATCHDOG_EN to build the stall watchdog (TIMEOUT cycles without a beat
//           revokes the grant); otherwise timeout_err is tied low.
module pixel_port_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       px_valid,
  input  logic [N_REQ-1:0]       px_last,
  input  logic [N_REQ*X_W-1:0]   px_x,
  input  logic [N_REQ*Y_W-1:0]   px_y,
  input  logic [N_REQ*COL_W-1:0] px_colour,
  output logic [N_REQ-1:0]       gnt,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] r_gidx, w_gidx_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [X_W-1:0]   r_vga_x, w_vga_x_nxt;
  logic [Y_W-1:0]   r_vga_y, w_vga_y_nxt;
  logic [COL_W-1:0] r_vga_col, w_vga_col_nxt;
  logic             r_vga_plot, w_vga_plot_nxt;

  logic [N_REQ-1:0] w_pick_oh;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_vld;

  // Signals of the currently granted requester (r_gidx is only meaningful in BURST).
  logic             w_beat, w_last, w_req_g;
  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [COL_W-1:0] w_sel_col;

  assign w_beat    = px_valid[r_gidx];
  assign w_last    = px_last[r_gidx];
  assign w_req_g   = req[r_gidx];
  assign w_sel_x   = px_x[X_W*int'(r_gidx) +: X_W];
  assign w_sel_y   = px_y[Y_W*int'(r_gidx) +: Y_W];
  assign w_sel_col = px_colour[COL_W*int'(r_gidx) +: COL_W];

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] idx);
    if (int'(idx) >= N_REQ - 1) begin
      return '0;
    end else begin
      return idx + 1'b1;
    end
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req        (req),
    .ptr        (r_ptr),
    .win_onehot (w_pick_oh),
    .win_idx    (w_pick_idx),
    .win_vld    (w_pick_vld)
  );

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic             w_wd_fire;

  // Fires on the stall cycle that brings the counter to TIMEOUT, so the grant
  // is revoked on that same edge.
  assign w_wd_fire = (r_state == BURST) && !w_beat && (r_wd_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gidx_nxt     = r_gidx;
    w_gnt_nxt      = r_gnt;
    w_vga_x_nxt    = r_vga_x;
    w_vga_y_nxt    = r_vga_y;
    w_vga_col_nxt  = r_vga_col;
    w_vga_plot_nxt = 1'b0;
`ifdef ARB_WATCHDOG_EN
    w_wd_cnt_nxt      = r_wd_cnt;
    w_timeout_err_nxt = r_timeout_err;
`endif

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = w_pick_oh;
          w_gidx_nxt  = w_pick_idx;
          w_ptr_nxt   = f_next_ptr(w_pick_idx);
`ifdef ARB_WATCHDOG_EN
          w_wd_cnt_nxt = '0;
`endif
        end
      end

      BURST: begin
        if (w_beat) begin
          w_vga_plot_nxt = 1'b1;
          w_vga_x_nxt    = w_sel_x;
          w_vga_y_nxt    = w_sel_y;
          w_vga_col_nxt  = w_sel_col;
        end
        // Last beat or a dropped request both end the burst; a beat seen in the
        // abort cycle has already been written above.
        if ((w_beat && w_last) || !w_req_g) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
`ifdef ARB_WATCHDOG_EN
        if (w_beat) begin
          w_wd_cnt_nxt = '0;
        end else if (w_wd_fire) begin
          w_state_nxt       = IDLE;
          w_gnt_nxt         = '0;
          w_ptr_nxt         = f_next_ptr(r_gidx);
          w_timeout_err_nxt = 1'b1;
          w_wd_cnt_nxt      = '0;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end
`endif
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    // Frame start always wins over a pointer update from a grant or timeout.
    if (frame_start) begin
      w_ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_gnt      <= '0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_vga_col  <= '0;
      r_vga_plot <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gidx     <= w_gidx_nxt;
      r_gnt      <= w_gnt_nxt;
      r_vga_x    <= w_vga_x_nxt;
      r_vga_y    <= w_vga_y_nxt;
      r_vga_col  <= w_vga_col_nxt;
      r_vga_plot <= w_vga_plot_nxt;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd_cnt      <= w_wd_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt        = r_gnt;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_col;
  assign vga_plot   = r_vga_plot;
  assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Purpose : directed self-checking bench for pixel_port_arbiter with a pixel scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_pixel_port_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic           frame_start;
  logic [N-1:0]   req;
  logic [N-1:0]   px_valid;
  logic [N-1:0]   px_last;
  logic [N*8-1:0] px_x;
  logic [N*7-1:0] px_y;
  logic [N*3-1:0] px_colour;
  logic [N-1:0]   gnt;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_plot = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  always #5 clk = ~clk;

  pixel_port_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_start (frame_start),
    .req         (req),
    .px_valid    (px_valid),
    .px_last     (px_last),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_colour   (px_colour),
    .gnt         (gnt),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_px();
    px_valid = '0;
    px_last  = '0;
  endtask

  // Drive one beat for requester r and record the pixel it must produce.
  task automatic beat(input int r, input int x, input int y, input int c, input bit last);
    px_valid[r]         = 1'b1;
    px_last[r]          = last;
    px_x[r*8 +: 8]      = 8'(x);
    px_y[r*7 +: 7]      = 7'(y);
    px_colour[r*3 +: 3] = 3'(c);
    exp_q.push_back({8'(x), 7'(y), 3'(c)});
    n_push++;
  endtask

  // Traffic from a requester that is not granted; must never reach the port.
  task automatic junk(input int r);
    px_valid[r]         = 1'b1;
    px_last[r]          = 1'b1;
    px_x[r*8 +: 8]      = 8'hEE;
    px_y[r*7 +: 7]      = 7'h55;
    px_colour[r*3 +: 3] = 3'h1;
  endtask

  task automatic fs_case(input logic [2:0] req_after, input int exp_idx, input int ybase);
    cyc(); req = 3'b010; smp(); chk("fs_gnt_wait", 32'(gnt), 32'd0);
    cyc(); clr_px(); beat(1, 30, ybase, 2, 1'b0); frame_start = 1'b1;
    smp(); chk("fs_gnt1", 32'(gnt), 32'b010);
    cyc(); frame_start = 1'b0; clr_px(); beat(1, 30, ybase + 1, 2, 1'b1); req = req_after;
    smp(); chk("fs_no_abort", 32'(gnt), 32'b010);
    cyc(); clr_px(); smp(); chk("fs_bubble", 32'(gnt), 32'd0);
    cyc(); clr_px(); beat(exp_idx, 31, ybase + 2, 5, 1'b1);
    smp(); chk("fs_next_gnt", 32'(gnt), 32'(1 << exp_idx));
    cyc(); clr_px(); req = '0; smp(); chk("fs_end", 32'(gnt), 32'd0);
  endtask

  // Scoreboard: every plot must match the oldest outstanding expected pixel.
  always @(negedge clk) begin
    if (resetn === 1'b1 && vga_plot === 1'b1) begin
      n_plot++;
      if (exp_q.size() == 0) begin
        chk("plot_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_e));
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    frame_start = 1'b0;
    req         = '0;
    px_valid    = '0;
    px_last     = '0;
    px_x        = '0;
    px_y        = '0;
    px_colour   = '0;

    repeat (3) cyc();
    smp();
    chk("rst_gnt",   32'(gnt),         32'd0);
    chk("rst_x",     32'(vga_x),       32'd0);
    chk("rst_y",     32'(vga_y),       32'd0);
    chk("rst_col",   32'(vga_colour),  32'd0);
    chk("rst_plot",  32'(vga_plot),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    cyc(); resetn = 1'b1;

    // Four-beat burst from the background renderer, with noise from requester 1.
    cyc(); req = 3'b001; smp(); chk("t1_gnt_wait", 32'(gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); clr_px(); beat(0, 10, 20 + i, 6, i == 3); junk(1);
      smp();
      chk("t1_gnt", 32'(gnt), 32'b001);
      chk("t1_busy", 32'(busy), 32'd1);
    end
    cyc(); clr_px(); req = '0; smp();
    chk("t1_gnt_end", 32'(gnt), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    cyc(); smp();
    chk("t1_plot_idle", 32'(vga_plot), 32'd0);
    chk("t1_hold_x", 32'(vga_x), 32'd10);
    chk("t1_hold_y", 32'(vga_y), 32'd23);

    // Round robin over single-beat bursts, from ptr=0.
    cyc(); frame_start = 1'b1; smp();
    cyc(); frame_start = 1'b0; req = 3'b111; smp(); chk("t2_gnt_wait", 32'(gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); clr_px(); beat(i % 3, 40 + i, 10 + i, i, 1'b1);
      smp(); chk("t2_gnt", 32'(gnt), 32'(1 << (i % 3)));
      cyc(); clr_px(); if (i == 3) req = '0;
      smp(); chk("t2_bubble", 32'(gnt), 32'd0);
    end

    // frame_start mid-burst resets the pointer without ending the burst.
    fs_case(3'b110, 1, 60);
    fs_case(3'b111, 0, 70);

    // Requester 2 aborts after two beats.
    cyc(); req = 3'b100; smp(); chk("t4_gnt_wait", 32'(gnt), 32'd0);
    cyc(); clr_px(); beat(2, 90, 50, 4, 1'b0); smp(); chk("t4_gnt_b0", 32'(gnt), 32'b100);
    cyc(); clr_px(); beat(2, 90, 51, 4, 1'b0); smp(); chk("t4_gnt_b1", 32'(gnt), 32'b100);
    cyc(); clr_px(); req = '0; smp(); chk("t4_gnt_abort_cyc", 32'(gnt), 32'b100);
    cyc(); smp();
    chk("t4_gnt_after", 32'(gnt), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);

    // Abort with a beat in the same cycle: the beat is still written.
    cyc(); req = 3'b001; smp();
    cyc(); clr_px(); beat(0, 91, 55, 7, 1'b0); req = '0; smp(); chk("t4b_gnt", 32'(gnt), 32'b001);
    cyc(); clr_px(); smp(); chk("t4b_gnt_after", 32'(gnt), 32'd0);

`ifdef ARB_WATCHDOG_EN
    cyc(); frame_start = 1'b1; smp();
    cyc(); frame_start = 1'b0; req = 3'b011; smp(); chk("wd_gnt_wait", 32'(gnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(); clr_px(); smp(); chk("wd_hold", 32'(gnt), 32'b001);
    end
    cyc(); smp();
    chk("wd_revoke", 32'(gnt), 32'd0);
    chk("wd_terr", 32'(timeout_err), 32'd1);
    cyc(); clr_px(); beat(1, 100, 80, 3, 1'b1); smp();
    chk("wd_next_gnt", 32'(gnt), 32'b010);
    cyc(); clr_px(); req = '0; smp();
    chk("wd_end", 32'(gnt), 32'd0);
    chk("wd_terr_sticky", 32'(timeout_err), 32'd1);
`else
    // Without the watchdog a stalled requester keeps the port.
    cyc(); req = 3'b001; smp();
    for (int i = 0; i < 12; i++) begin
      cyc(); clr_px(); smp();
      chk("stall_hold", 32'(gnt), 32'b001);
      chk("stall_terr", 32'(timeout_err), 32'd0);
    end
    cyc(); clr_px(); beat(0, 100, 80, 3, 1'b1); smp(); chk("stall_gnt", 32'(gnt), 32'b001);
    cyc(); clr_px(); req = '0; smp(); chk("stall_end", 32'(gnt), 32'd0);
`endif

    // Reset mid-burst: grant requester 0 so its pointer advance would be visible.
    cyc(); req = 3'b001; smp();
    cyc(); clr_px(); beat(0, 120, 100, 5, 1'b0); smp(); chk("rb_gnt", 32'(gnt), 32'b001);
    cyc(); clr_px(); smp();
    #2;
    resetn = 1'b0;
    req    = '0;
    #1;
    chk("rb_gnt0",  32'(gnt),         32'd0);
    chk("rb_x0",    32'(vga_x),       32'd0);
    chk("rb_y0",    32'(vga_y),       32'd0);
    chk("rb_col0",  32'(vga_colour),  32'd0);
    chk("rb_plot0", 32'(vga_plot),    32'd0);
    chk("rb_busy0", 32'(busy),        32'd0);
    chk("rb_terr0", 32'(timeout_err), 32'd0);
    cyc(); cyc(); resetn = 1'b1;
    cyc(); req = 3'b111; smp(); chk("rb_gnt_wait", 32'(gnt), 32'd0);
    cyc(); clr_px(); beat(0, 121, 101, 6, 1'b1); smp(); chk("rb_post_gnt", 32'(gnt), 32'b001);
    cyc(); clr_px(); req = '0; smp(); chk("rb_post_end", 32'(gnt), 32'd0);

    cyc(); smp();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("plot_count", 32'(n_plot), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
